// File: rtl/bullet_pkg.sv
// Shared types and constants for the bullet spawner: type codes, FSM
// encoding, default cooldowns and coordinate widths.
package bullet_pkg;

    localparam int NUM_BULLET_TYPES = 5;

    // Bullet type codes as carried on spawn_type
    localparam logic [2:0] TYPE_0 = 3'd0;
    localparam logic [2:0] TYPE_1 = 3'd1;
    localparam logic [2:0] TYPE_2 = 3'd2;
    localparam logic [2:0] TYPE_3 = 3'd3;
    localparam logic [2:0] TYPE_4 = 3'd4;

    // Largest legal value of the 5-bit select code
    localparam logic [4:0] MAX_TYPE_CODE = 5'(NUM_BULLET_TYPES - 1);

    // Default cooldowns in frame ticks
    localparam logic [7:0] CD0_DEF = 8'd10;
    localparam logic [7:0] CD1_DEF = 8'd20;
    localparam logic [7:0] CD2_DEF = 8'd30;
    localparam logic [7:0] CD3_DEF = 8'd45;
    localparam logic [7:0] CD4_DEF = 8'd60;

    localparam logic [15:0] DEB_CYCLES_DEF = 16'd50000;

    // Coordinate widths (640x480 playfield)
    localparam int X_W_DEF = 10;
    localparam int Y_W_DEF = 9;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SPAWN    = 2'd1,
        ST_COOLDOWN = 2'd2
    } state_e;

    // One-hot decode of the select code; illegal codes decode to all zeros
    function automatic logic [4:0] sel_to_onehot(input logic [4:0] sel);
        case (sel)
            5'd0:    return 5'b00001;
            5'd1:    return 5'b00010;
            5'd2:    return 5'b00100;
            5'd3:    return 5'b01000;
            5'd4:    return 5'b10000;
            default: return 5'b00000;
        endcase
    endfunction

endpackage

// File: rtl/bullet_spawner_if.sv
// Spawn handshake between the spawner (master) and the bullet pool (slave).
interface bullet_spawner_if
    import bullet_pkg::*;
#(
    parameter int X_W = X_W_DEF,
    parameter int Y_W = Y_W_DEF
) ();

    logic           spawn_valid;
    logic           spawn_ready;
    logic [2:0]     spawn_type;
    logic [X_W-1:0] spawn_x;
    logic [Y_W-1:0] spawn_y;

    modport master (
        output spawn_valid,
        output spawn_type,
        output spawn_x,
        output spawn_y,
        input  spawn_ready
    );

    modport slave (
        input  spawn_valid,
        input  spawn_type,
        input  spawn_x,
        input  spawn_y,
        output spawn_ready
    );

endinterface

// File: rtl/bullet_spawner_shoot_debounce.sv
// Synchronises and debounces the active-low fire button and emits a
// one-cycle press pulse in the cycle the debounced level first reads low.
module shoot_debounce
    import bullet_pkg::*;
#(
    parameter logic [15:0] DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_shoot,
    output logic o_press
);

    logic        r_sync1;
    logic        r_sync2;
    logic        r_level;
    logic [15:0] r_cnt;
    logic        r_press;

    // Two-flop synchroniser; idles high so reset looks like a released button
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_shoot;
            r_sync2 <= r_sync1;
        end
    end

    // Stability counter: level follows the input only after a full run of disagreement
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= 1'b1;
            r_cnt   <= 16'd0;
            r_press <= 1'b0;
        end else begin
            r_press <= 1'b0;
            if (r_sync2 != r_level) begin
                if (r_cnt == DEB_CYCLES - 16'd1) begin
                    r_level <= r_sync2;
                    r_cnt   <= 16'd0;
                    // only the falling edge of the debounced level is a press
                    r_press <= ~r_sync2;
                end else begin
                    r_cnt <= r_cnt + 16'd1;
                end
            end else begin
                r_cnt <= 16'd0;
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/bullet_spawner.sv
// Turns debounced fire presses into single bullet-spawn requests with a
// latched type/position payload, then locks out further presses for a
// per-type number of frame ticks.
module bullet_spawner
    import bullet_pkg::*;
#(
    parameter logic [15:0] DEB_CYCLES = DEB_CYCLES_DEF,
    parameter logic [7:0]  CD0        = CD0_DEF,
    parameter logic [7:0]  CD1        = CD1_DEF,
    parameter logic [7:0]  CD2        = CD2_DEF,
    parameter logic [7:0]  CD3        = CD3_DEF,
    parameter logic [7:0]  CD4        = CD4_DEF,
    parameter int          X_W        = X_W_DEF,
    parameter int          Y_W        = Y_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tick,
    input  logic                  shoot,
    input  logic [4:0]            bullet_sel,
    input  logic [X_W-1:0]        player_x,
    input  logic [Y_W-1:0]        player_y,
    bullet_spawner_if.master      spawn_if,
    output logic [4:0]            type_onehot,
    output logic                  cooling,
    output logic                  drop_pulse
);

    state_e         r_state;
    logic           r_spawn_valid;
    logic [2:0]     r_spawn_type;
    logic [X_W-1:0] r_spawn_x;
    logic [Y_W-1:0] r_spawn_y;
    logic [7:0]     r_cd_cnt;
    logic           r_cooling;
    logic           r_drop_pulse;
    logic [4:0]     r_type_onehot;
    logic           w_press;
    logic [7:0]     w_cd_load;

    shoot_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_debounce (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_shoot (shoot),
        .o_press (w_press)
    );

    // Cooldown length for the type currently held in the payload register
    always_comb begin
        w_cd_load = 8'd0;
        case (r_spawn_type)
            TYPE_0:  w_cd_load = CD0;
            TYPE_1:  w_cd_load = CD1;
            TYPE_2:  w_cd_load = CD2;
            TYPE_3:  w_cd_load = CD3;
            TYPE_4:  w_cd_load = CD4;
            default: w_cd_load = 8'd0;
        endcase
    end

    // Free-running registered decode of the type select
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_type_onehot <= 5'b00000;
        end else begin
            r_type_onehot <= sel_to_onehot(bullet_sel);
        end
    end

    // Spawn FSM with payload, cooldown counter and drop indication
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_spawn_valid <= 1'b0;
            r_spawn_type  <= 3'd0;
            r_spawn_x     <= '0;
            r_spawn_y     <= '0;
            r_cd_cnt      <= 8'd0;
            r_cooling     <= 1'b0;
            r_drop_pulse  <= 1'b0;
        end else begin
            r_drop_pulse <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_press) begin
                        if (bullet_sel <= MAX_TYPE_CODE) begin
                            r_spawn_type  <= bullet_sel[2:0];
                            r_spawn_x     <= player_x;
                            r_spawn_y     <= player_y;
                            r_spawn_valid <= 1'b1;
                            r_state       <= ST_SPAWN;
                        end else begin
                            r_drop_pulse <= 1'b1;
                        end
                    end
                end
                ST_SPAWN: begin
                    // presses are never queued behind a pending spawn
                    if (w_press) begin
                        r_drop_pulse <= 1'b1;
                    end
                    if (r_spawn_valid && spawn_if.spawn_ready) begin
                        r_spawn_valid <= 1'b0;
                        if (w_cd_load == 8'd0) begin
                            r_state <= ST_IDLE;
                        end else begin
                            // a tick in this cycle is deliberately not counted
                            r_cd_cnt  <= w_cd_load;
                            r_cooling <= 1'b1;
                            r_state   <= ST_COOLDOWN;
                        end
                    end
                end
                ST_COOLDOWN: begin
                    if (w_press) begin
                        r_drop_pulse <= 1'b1;
                    end
                    if (tick) begin
                        if (r_cd_cnt <= 8'd1) begin
                            r_cd_cnt  <= 8'd0;
                            r_cooling <= 1'b0;
                            r_state   <= ST_IDLE;
                        end else begin
                            r_cd_cnt <= r_cd_cnt - 8'd1;
                        end
                    end
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_spawn_valid <= 1'b0;
                    r_cd_cnt      <= 8'd0;
                    r_cooling     <= 1'b0;
                end
            endcase
        end
    end

    assign spawn_if.spawn_valid = r_spawn_valid;
    assign spawn_if.spawn_type  = r_spawn_type;
    assign spawn_if.spawn_x     = r_spawn_x;
    assign spawn_if.spawn_y     = r_spawn_y;
    assign type_onehot          = r_type_onehot;
    assign cooling              = r_cooling;
    assign drop_pulse           = r_drop_pulse;

endmodule

// File: tb/tb_bullet_spawner.sv
// Bench for bullet_spawner: a behavioural model (history-based debounce,
// busy/pending/ticks-left bookkeeping) is compared against the DUT on every
// falling clock edge, and directed scenarios pin the model with literals.
module tb_bullet_spawner;

    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       shoot = 1'b1;
    logic [4:0] bullet_sel = 5'd0;
    logic [9:0] player_x = 10'd0;
    logic [8:0] player_y = 9'd0;
    logic [4:0] type_onehot;
    logic       cooling;
    logic       drop_pulse;

    bullet_spawner_if #(.X_W(10), .Y_W(9)) sif ();

    bullet_spawner #(
        .DEB_CYCLES (16'd4),
        .X_W        (10),
        .Y_W        (9)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick        (tick),
        .shoot       (shoot),
        .bullet_sel  (bullet_sel),
        .player_x    (player_x),
        .player_y    (player_y),
        .spawn_if    (sif),
        .type_onehot (type_onehot),
        .cooling     (cooling),
        .drop_pulse  (drop_pulse)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int cd_of(input int t);
        case (t)
            0: return 10;
            1: return 20;
            2: return 30;
            3: return 45;
            4: return 60;
            default: return 0;
        endcase
    endfunction

    // ---------------- behavioural model ----------------
    int m_s1, m_s2, m_level;
    int m_hist[$];
    bit m_press;
    bit m_pend;
    int m_type, m_x, m_y, m_cd;
    bit m_drop;
    int m_oh;
    bit m_busy, m_flip;
    int m_synced;

    task automatic model_reset();
        m_s1 = 1; m_s2 = 1; m_level = 1;
        m_hist.delete();
        m_press = 0; m_pend = 0;
        m_type = 0; m_x = 0; m_y = 0; m_cd = 0;
        m_drop = 0; m_oh = 0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                m_busy = m_pend || (m_cd > 0);
                m_drop = 0;
                if (m_pend && sif.spawn_ready) begin
                    m_pend = 0;
                    m_cd   = cd_of(m_type);
                end else if (m_cd > 0 && tick) begin
                    m_cd = m_cd - 1;
                end
                if (m_press) begin
                    if (!m_busy && bullet_sel <= 5'd4) begin
                        m_pend = 1;
                        m_type = int'(bullet_sel);
                        m_x    = int'(player_x);
                        m_y    = int'(player_y);
                    end else begin
                        m_drop = 1;
                    end
                end
                m_oh = (bullet_sel <= 5'd4) ? (1 << bullet_sel) : 0;
                m_synced = m_s2;
                m_s2 = m_s1;
                m_s1 = int'(shoot);
                m_hist.push_back(m_synced);
                if (m_hist.size() > DEB) void'(m_hist.pop_front());
                m_press = 0;
                if (m_hist.size() == DEB) begin
                    m_flip = 1;
                    for (int i = 0; i < DEB; i++)
                        if (m_hist[i] == m_level) m_flip = 0;
                    if (m_flip) begin
                        m_level = m_synced;
                        m_press = (m_level == 0);
                    end
                end
            end
        end
    end

    // ---------------- compare and observe ----------------
    int n_xfer = 0, n_drop = 0, n_cool_ticks = 0;
    int last_type = -1, last_x = -1, last_y = -1;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("spawn_valid", {31'd0, sif.spawn_valid}, {31'd0, m_pend});
                check("spawn_type", {29'd0, sif.spawn_type}, m_type);
                check("spawn_x", {22'd0, sif.spawn_x}, m_x);
                check("spawn_y", {23'd0, sif.spawn_y}, m_y);
                check("type_onehot", {27'd0, type_onehot}, m_oh);
                check("cooling", {31'd0, cooling}, {31'd0, (m_cd > 0)});
                check("drop_pulse", {31'd0, drop_pulse}, {31'd0, m_drop});
                if (sif.spawn_valid && sif.spawn_ready) begin
                    n_xfer++;
                    last_type = int'(sif.spawn_type);
                    last_x    = int'(sif.spawn_x);
                    last_y    = int'(sif.spawn_y);
                end
                if (drop_pulse) n_drop++;
                if (tick && cooling) n_cool_ticks++;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            cyc(1);
            tick = 1'b0;
            cyc(1);
        end
    endtask

    task automatic full_press();
        shoot = 1'b0;
        cyc(10);
        shoot = 1'b1;
        cyc(10);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        sif.spawn_ready = 1'b0;
        cyc(3);
        @(negedge clk);
        check("rst_valid", {31'd0, sif.spawn_valid}, 32'd0);
        check("rst_onehot", {27'd0, type_onehot}, 32'd0);
        check("rst_cooling", {31'd0, cooling}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc(2);

        // 3-cycle glitch shorter than the debounce window
        shoot = 1'b0;
        cyc(3);
        shoot = 1'b1;
        cyc(12);
        check("glitch_xfer", n_xfer, 32'd0);
        check("glitch_drop", n_drop, 32'd0);
        check("glitch_valid", {31'd0, sif.spawn_valid}, 32'd0);

        // type 2 at (320,400), pool always ready, cooldown 30 ticks
        bullet_sel = 5'd2; player_x = 10'd320; player_y = 9'd400;
        sif.spawn_ready = 1'b1;
        full_press();
        tick_n(35);
        check("t2_xfer", n_xfer, 32'd1);
        check("t2_type", last_type, 32'd2);
        check("t2_x", last_x, 32'd320);
        check("t2_y", last_y, 32'd400);
        check("t2_cool_ticks", n_cool_ticks, 32'd30);
        check("t2_cool_end", {31'd0, cooling}, 32'd0);

        // back-pressure: ready low for 7 valid cycles, player moves meanwhile
        bullet_sel = 5'd1; player_x = 10'd100; player_y = 9'd50;
        sif.spawn_ready = 1'b0;
        shoot = 1'b0;
        cyc(8);
        check("bp_valid_early", {31'd0, sif.spawn_valid}, 32'd1);
        player_x = 10'd555;
        shoot = 1'b1;
        cyc(6);
        check("bp_valid_held", {31'd0, sif.spawn_valid}, 32'd1);
        check("bp_x_held", {22'd0, sif.spawn_x}, 32'd100);
        sif.spawn_ready = 1'b1;
        @(negedge clk);
        check("bp_xfer_cycle", {31'd0, sif.spawn_valid}, 32'd1);
        cyc(1);
        check("bp_valid_after", {31'd0, sif.spawn_valid}, 32'd0);
        check("bp_xfer", n_xfer, 32'd2);
        check("bp_x", last_x, 32'd100);
        check("bp_type", last_type, 32'd1);
        tick_n(25);

        // illegal type code: dropped, no spawn
        bullet_sel = 5'd7;
        shoot = 1'b0;
        cyc(12);
        check("bad_onehot", {27'd0, type_onehot}, 32'd0);
        shoot = 1'b1;
        cyc(10);
        check("bad_drop", n_drop, 32'd1);
        check("bad_xfer", n_xfer, 32'd2);
        check("bad_valid", {31'd0, sif.spawn_valid}, 32'd0);

        // type 0 cooldown (10 ticks): press on tick 5 dropped
        bullet_sel = 5'd0;
        full_press();
        check("t0_onehot", {27'd0, type_onehot}, 32'd1);
        tick_n(4);
        shoot = 1'b0;
        cyc(6);
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        cyc(4);
        shoot = 1'b1;
        cyc(10);
        check("t0_mid_drop", n_drop, 32'd2);
        check("t0_mid_xfer", n_xfer, 32'd3);
        // press one cycle after the 10th tick is accepted
        tick_n(4);
        shoot = 1'b0;
        cyc(5);
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        cyc(4);
        shoot = 1'b1;
        cyc(10);
        check("t0_after_xfer", n_xfer, 32'd4);
        check("t0_after_drop", n_drop, 32'd2);
        // press coinciding with the final tick is dropped
        tick_n(9);
        shoot = 1'b0;
        cyc(6);
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        cyc(4);
        shoot = 1'b1;
        cyc(10);
        check("t0_final_drop", n_drop, 32'd3);
        check("t0_final_xfer", n_xfer, 32'd4);
        check("t0_final_cool", {31'd0, cooling}, 32'd0);

        // reset while a spawn is pending
        sif.spawn_ready = 1'b0;
        bullet_sel = 5'd3; player_x = 10'd7; player_y = 9'd8;
        shoot = 1'b0;
        cyc(8);
        check("pre_rst_valid", {31'd0, sif.spawn_valid}, 32'd1);
        shoot = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", {31'd0, sif.spawn_valid}, 32'd0);
        cyc(2);
        rst_n = 1'b1;
        cyc(3);
        check("post_rst_valid", {31'd0, sif.spawn_valid}, 32'd0);
        sif.spawn_ready = 1'b1;
        bullet_sel = 5'd4; player_x = 10'd639; player_y = 9'd479;
        full_press();
        check("post_rst_xfer", n_xfer, 32'd5);
        check("post_rst_type", last_type, 32'd4);
        check("post_rst_x", last_x, 32'd639);
        check("post_rst_y", last_y, 32'd479);
        check("post_rst_cool", {31'd0, cooling}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
